// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the multicycle controller: states, opcode/opext, cond codes,
// datapath select values, and the instruction-class decode helper.
package cpu_controller_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FIELD_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH      = 4'd0,
    ST_FETCH_WAIT = 4'd1,
    ST_DECODE     = 4'd2,
    ST_EXEC_R     = 4'd3,
    ST_EXEC_CMP   = 4'd4,
    ST_EXEC_I     = 4'd5,
    ST_LD_ADDR    = 4'd6,
    ST_LD_WB      = 4'd7,
    ST_ST         = 4'd8,
    ST_BR         = 4'd9,
    ST_JMP        = 4'd10,
    ST_JAL        = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_MOV, CLS_CMP, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JMP, CLS_JAL
  } op_class_t;

  typedef enum logic [1:0] {
    PC_SRC_INC  = 2'd0,
    PC_SRC_REG  = 2'd1,
    PC_SRC_DISP = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_t;

  // opcode field, instr[15:12]
  localparam logic [FIELD_W-1:0] OPC_RTYPE = 4'b0000;
  localparam logic [FIELD_W-1:0] OPC_ANDI  = 4'b0001;
  localparam logic [FIELD_W-1:0] OPC_ORI   = 4'b0010;
  localparam logic [FIELD_W-1:0] OPC_XORI  = 4'b0011;
  localparam logic [FIELD_W-1:0] OPC_MEM   = 4'b0100;
  localparam logic [FIELD_W-1:0] OPC_ADDI  = 4'b0101;
  localparam logic [FIELD_W-1:0] OPC_SUBI  = 4'b1001;
  localparam logic [FIELD_W-1:0] OPC_CMPI  = 4'b1011;
  localparam logic [FIELD_W-1:0] OPC_BCOND = 4'b1100;
  localparam logic [FIELD_W-1:0] OPC_MOVI  = 4'b1101;

  // opext field, instr[7:4]
  localparam logic [FIELD_W-1:0] EXT_AND   = 4'b0001;
  localparam logic [FIELD_W-1:0] EXT_OR    = 4'b0010;
  localparam logic [FIELD_W-1:0] EXT_XOR   = 4'b0011;
  localparam logic [FIELD_W-1:0] EXT_ADD   = 4'b0101;
  localparam logic [FIELD_W-1:0] EXT_SUB   = 4'b1001;
  localparam logic [FIELD_W-1:0] EXT_CMP   = 4'b1011;
  localparam logic [FIELD_W-1:0] EXT_MOV   = 4'b1101;
  localparam logic [FIELD_W-1:0] EXT_LOAD  = 4'b0000;
  localparam logic [FIELD_W-1:0] EXT_STOR  = 4'b0100;
  localparam logic [FIELD_W-1:0] EXT_JAL   = 4'b1000;
  localparam logic [FIELD_W-1:0] EXT_JCOND = 4'b1100;

  // cond field, instr[11:8]
  localparam logic [FIELD_W-1:0] COND_EQ = 4'b0000;
  localparam logic [FIELD_W-1:0] COND_NE = 4'b0001;
  localparam logic [FIELD_W-1:0] COND_CS = 4'b0010;
  localparam logic [FIELD_W-1:0] COND_CC = 4'b0011;
  localparam logic [FIELD_W-1:0] COND_LO = 4'b0100;
  localparam logic [FIELD_W-1:0] COND_HS = 4'b0101;
  localparam logic [FIELD_W-1:0] COND_LT = 4'b0110;
  localparam logic [FIELD_W-1:0] COND_GE = 4'b0111;
  localparam logic [FIELD_W-1:0] COND_UC = 4'b1110;

  typedef struct packed {
    logic      legal;
    op_class_t cls;
    state_t    target;
  } decode_t;

  // Illegal encodings report legal=0 with target FETCH and class NOP.
  function automatic decode_t decode_instr(input logic [FIELD_W-1:0] opcode,
                                           input logic [FIELD_W-1:0] opext);
    decode_t d;
    d.legal  = 1'b1;
    d.cls    = CLS_NOP;
    d.target = ST_FETCH;
    case (opcode)
      OPC_RTYPE: begin
        case (opext)
          EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB: begin
            d.cls = CLS_ALU; d.target = ST_EXEC_R;
          end
          EXT_MOV: begin d.cls = CLS_MOV; d.target = ST_EXEC_R;   end
          EXT_CMP: begin d.cls = CLS_CMP; d.target = ST_EXEC_CMP; end
          default: d.legal = 1'b0;
        endcase
      end
      OPC_ANDI, OPC_ORI, OPC_XORI, OPC_ADDI, OPC_SUBI: begin
        d.cls = CLS_ALU; d.target = ST_EXEC_I;
      end
      OPC_MOVI: begin d.cls = CLS_MOV; d.target = ST_EXEC_I; end
      OPC_CMPI: begin d.cls = CLS_CMP; d.target = ST_EXEC_I; end
      OPC_MEM: begin
        case (opext)
          EXT_LOAD:  begin d.cls = CLS_LOAD;  d.target = ST_LD_ADDR; end
          EXT_STOR:  begin d.cls = CLS_STORE; d.target = ST_ST;      end
          EXT_JCOND: begin d.cls = CLS_JMP;   d.target = ST_JMP;     end
          EXT_JAL:   begin d.cls = CLS_JAL;   d.target = ST_JAL;     end
          default:   d.legal = 1'b0;
        endcase
      end
      OPC_BCOND: begin d.cls = CLS_BR; d.target = ST_BR; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch/jump condition evaluation from the cond field and the flags register.
module cpu_controller_cond_eval
  import cpu_controller_pkg::*;
(
  input  logic [FIELD_W-1:0] cond,
  input  logic               z,
  input  logic               c,
  input  logic               n,
  input  logic               l,
  output logic               cond_true_c
);

  always_comb begin
    cond_true_c = 1'b0;
    case (cond)
      COND_EQ: cond_true_c = z;
      COND_NE: cond_true_c = ~z;
      COND_CS: cond_true_c = c;
      COND_CC: cond_true_c = ~c;
      COND_LO: cond_true_c = l;
      COND_HS: cond_true_c = ~l;
      COND_LT: cond_true_c = n;
      COND_GE: cond_true_c = ~n;
      COND_UC: cond_true_c = 1'b1;
      default: cond_true_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle fetch/decode/execute/writeback sequencer; Moore outputs decoded from
// the state and the latched op class, with cond/flags gating pc_en in BR and JMP.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STATEBITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [FIELD_W-1:0]   opcode,
  input  logic [FIELD_W-1:0]   opext,
  input  logic [FIELD_W-1:0]   cond,
  input  logic                 z,
  input  logic                 c,
  input  logic                 n,
  input  logic                 l,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 irwrite,
  output logic                 mem_addr_sel,
  output logic                 we_a,
  output logic                 regwrite,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_imm,
  output logic                 flag_write,
  output logic                 retire,
  output logic [WIDTH-1:0]     retired,
  output logic [STATEBITS-1:0] state
);

  state_t    state_q, next_state;
  op_class_t cls_q;
  decode_t   dec;
  logic      cond_true_c;

  cpu_controller_cond_eval u_cond_eval (
    .cond        (cond),
    .z           (z),
    .c           (c),
    .n           (n),
    .l           (l),
    .cond_true_c (cond_true_c)
  );

  assign dec   = decode_instr(opcode, opext);
  assign state = STATEBITS'(state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= next_state;
  end

  // Op class is captured while the IR is stable in DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    cls_q <= CLS_NOP;
    else if (state_q == ST_DECODE) cls_q <= dec.cls;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= '0;
    else if (retire) retired <= retired + WIDTH'(1);
  end

  always_comb begin
    next_state   = ST_FETCH;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_INC;
    irwrite      = 1'b0;
    mem_addr_sel = 1'b0;
    we_a         = 1'b0;
    regwrite     = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_imm  = 1'b0;
    flag_write   = 1'b0;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: next_state = run ? ST_FETCH_WAIT : ST_FETCH;
      ST_FETCH_WAIT: begin
        irwrite    = 1'b1;
        pc_en      = 1'b1;
        next_state = ST_DECODE;
      end
      // An illegal encoding retires here: the IR is only valid from DECODE on.
      ST_DECODE: begin
        next_state = dec.target;
        retire     = ~dec.legal;
      end
      ST_EXEC_R: begin
        regwrite   = 1'b1;
        flag_write = (cls_q != CLS_MOV);
        retire     = 1'b1;
      end
      ST_EXEC_CMP: begin
        flag_write = 1'b1;
        retire     = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_imm = 1'b1;
        regwrite    = (cls_q != CLS_CMP);
        flag_write  = (cls_q != CLS_MOV);
        retire      = 1'b1;
      end
      ST_LD_ADDR: begin
        mem_addr_sel = 1'b1;
        next_state   = ST_LD_WB;
      end
      ST_LD_WB: begin
        mem_addr_sel = 1'b1;
        regwrite     = 1'b1;
        wb_sel       = WB_MEM;
        retire       = 1'b1;
      end
      ST_ST: begin
        mem_addr_sel = 1'b1;
        we_a         = 1'b1;
        retire       = 1'b1;
      end
      ST_BR: begin
        pc_src = PC_SRC_DISP;
        pc_en  = cond_true_c;
        retire = 1'b1;
      end
      ST_JMP: begin
        pc_src = PC_SRC_REG;
        pc_en  = cond_true_c;
        retire = 1'b1;
      end
      ST_JAL: begin
        regwrite = 1'b1;
        wb_sel   = WB_PC;
        pc_src   = PC_SRC_REG;
        pc_en    = 1'b1;
        retire   = 1'b1;
      end
      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed table, hand sequences for reset/run/wrap,
// and random instructions checked cycle by cycle against a behavioural model.
module tb_cpu_controller;

  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [3:0]    opcode, opext, cond;
  logic          z, c, n, l;
  logic          pc_en, irwrite, mem_addr_sel, we_a, regwrite, alu_src_imm, flag_write, retire;
  logic [1:0]    pc_src, wb_sel;
  logic [TW-1:0] retired;
  logic [3:0]    state;

  cpu_controller #(.WIDTH(TW), .STATEBITS(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .opext(opext), .cond(cond),
    .z(z), .c(c), .n(n), .l(l), .pc_en(pc_en), .pc_src(pc_src), .irwrite(irwrite),
    .mem_addr_sel(mem_addr_sel), .we_a(we_a), .regwrite(regwrite), .wb_sel(wb_sel),
    .alu_src_imm(alu_src_imm), .flag_write(flag_write), .retire(retire),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       irwrite;
    logic       mem_addr_sel;
    logic       we_a;
    logic       regwrite;
    logic [1:0] wb_sel;
    logic       alu_src_imm;
    logic       flag_write;
    logic       retire;
  } out_t;

  typedef struct {
    logic [3:0] op, ext, cnd, fl;
    int         len;
    out_t       last;
  } vec_t;

  localparam logic [3:0] FETCH_ENC = 4'(cpu_controller_pkg::ST_FETCH);

  int            total = 0;
  int            bad = 0;
  logic [TW-1:0] model_ret;
  out_t          obs_q[$];
  out_t          exp_q[$];
  vec_t          tbl[14];
  logic [3:0]    ext_pool[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.pc_en = pc_en; o.pc_src = pc_src; o.irwrite = irwrite; o.mem_addr_sel = mem_addr_sel;
    o.we_a = we_a; o.regwrite = regwrite; o.wb_sel = wb_sel; o.alu_src_imm = alu_src_imm;
    o.flag_write = flag_write; o.retire = retire;
    return o;
  endfunction

  // Final-state output vector; retire is always set there.
  function automatic out_t mk(input bit pe, input logic [1:0] ps, input bit ma, input bit we,
                              input bit rw, input logic [1:0] wb, input bit im, input bit fw);
    out_t o;
    o = '0;
    o.pc_en = pe; o.pc_src = ps; o.mem_addr_sel = ma; o.we_a = we;
    o.regwrite = rw; o.wb_sel = wb; o.alu_src_imm = im; o.flag_write = fw; o.retire = 1'b1;
    return o;
  endfunction

  // fl = {z, c, n, l}; conditions 0..7 pick a flag by pair, odd codes invert it.
  function automatic bit cond_model(input logic [3:0] cnd, input logic [3:0] fl);
    bit f;
    if (cnd == 4'd14) return 1'b1;
    if (cnd > 4'd7) return 1'b0;
    case (cnd[2:1])
      2'd0: f = fl[3];
      2'd1: f = fl[2];
      2'd2: f = fl[0];
      default: f = fl[1];
    endcase
    return f ^ cnd[0];
  endfunction

  // Expected per-cycle outputs for one instruction, starting in FETCH with run=1.
  function automatic void build_expected(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [3:0] cnd, input logic [3:0] fl);
    out_t fw, mid, last;
    bit   imm, alu, mov, cmp;
    exp_q.delete();
    fw = '0; fw.irwrite = 1'b1; fw.pc_en = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back(fw);
    imm = op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13};
    alu = (op == 4'd0 && ext inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9}) ||
          op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9};
    mov = (op == 4'd0 && ext == 4'd13) || op == 4'd13;
    cmp = (op == 4'd0 && ext == 4'd11) || op == 4'd11;
    mid = '0;
    if (alu || mov || cmp)                   last = mk(0, 2'd0, 0, 0, !cmp, 2'd0, imm, !mov);
    else if (op == 4'd12)                    last = mk(cond_model(cnd, fl), 2'd2, 0, 0, 0, 2'd0, 0, 0);
    else if (op == 4'd4 && ext == 4'd0) begin
      mid.mem_addr_sel = 1'b1;
      last = mk(0, 2'd0, 1, 0, 1, 2'd1, 0, 0);
    end
    else if (op == 4'd4 && ext == 4'd4)      last = mk(0, 2'd0, 1, 1, 0, 2'd0, 0, 0);
    else if (op == 4'd4 && ext == 4'd12)     last = mk(cond_model(cnd, fl), 2'd1, 0, 0, 0, 2'd0, 0, 0);
    else if (op == 4'd4 && ext == 4'd8)      last = mk(1, 2'd1, 0, 0, 1, 2'd2, 0, 0);
    else begin
      exp_q.push_back(mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0));
      return;
    end
    exp_q.push_back('0);
    if (mid.mem_addr_sel) exp_q.push_back(mid);
    exp_q.push_back(last);
  endfunction

  // Runs one instruction from FETCH, recording outputs each cycle until retire is seen.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                           input logic [3:0] cnd, input logic [3:0] fl);
    bit done = 1'b0;
    obs_q.delete();
    opcode = op; opext = ext; cond = cnd; {z, c, n, l} = fl; run = 1'b1;
    #1;
    for (int i = 0; i < 10 && !done; i++) begin
      obs_q.push_back(sample());
      if (retire) done = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL retire_timeout: op=%0h ext=%0h never retired", op, ext);
    end
    model_ret = model_ret + TW'(1);
  endtask

  task automatic after_checks(input string name);
    chk({name, "_state"}, 32'(state), 32'(FETCH_ENC));
    chk({name, "_retired"}, 32'(retired), 32'(model_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_t fwv;
    int   we_cnt;
    logic [3:0] op, ext, cnd, fl;

    fwv = '0; fwv.irwrite = 1'b1; fwv.pc_en = 1'b1;
    tbl[0]  = '{4'h0, 4'h5, 4'h0, 4'h0, 4, mk(0, 2'd0, 0, 0, 1, 2'd0, 0, 1)};  // ADD
    tbl[1]  = '{4'h0, 4'hD, 4'h0, 4'h0, 4, mk(0, 2'd0, 0, 0, 1, 2'd0, 0, 0)};  // MOV
    tbl[2]  = '{4'h0, 4'hB, 4'h0, 4'h0, 4, mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 1)};  // CMP
    tbl[3]  = '{4'h5, 4'h7, 4'h0, 4'h0, 4, mk(0, 2'd0, 0, 0, 1, 2'd0, 1, 1)};  // ADDI
    tbl[4]  = '{4'hB, 4'h2, 4'h0, 4'h0, 4, mk(0, 2'd0, 0, 0, 0, 2'd0, 1, 1)};  // CMPI
    tbl[5]  = '{4'h4, 4'h0, 4'h0, 4'h0, 5, mk(0, 2'd0, 1, 0, 1, 2'd1, 0, 0)};  // LOAD
    tbl[6]  = '{4'h4, 4'h4, 4'h0, 4'h0, 4, mk(0, 2'd0, 1, 1, 0, 2'd0, 0, 0)};  // STOR
    tbl[7]  = '{4'hC, 4'h0, 4'h0, 4'h8, 4, mk(1, 2'd2, 0, 0, 0, 2'd0, 0, 0)};  // BR EQ, z=1
    tbl[8]  = '{4'hC, 4'h0, 4'h0, 4'h7, 4, mk(0, 2'd2, 0, 0, 0, 2'd0, 0, 0)};  // BR EQ, z=0
    tbl[9]  = '{4'hC, 4'h0, 4'hF, 4'hF, 4, mk(0, 2'd2, 0, 0, 0, 2'd0, 0, 0)};  // BR never
    tbl[10] = '{4'h4, 4'hC, 4'hE, 4'h0, 4, mk(1, 2'd1, 0, 0, 0, 2'd0, 0, 0)};  // JMP always
    tbl[11] = '{4'h4, 4'h8, 4'h0, 4'h0, 4, mk(1, 2'd1, 0, 0, 1, 2'd2, 0, 0)};  // JAL
    tbl[12] = '{4'h7, 4'h0, 4'h0, 4'h0, 3, mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0)};  // illegal opcode
    tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 3, mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0)};  // illegal opext
    ext_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13};

    reset = 1'b0; run = 1'b0; opcode = '0; opext = '0; cond = '0; {z, c, n, l} = 4'h0;
    model_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(sample()), 32'd0);
    chk("reset_state", 32'(state), 32'(FETCH_ENC));
    chk("reset_retired", 32'(retired), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].ext, tbl[i].cnd, tbl[i].fl);
      chk($sformatf("tbl%0d_len", i), 32'(obs_q.size()), 32'(tbl[i].len));
      if (obs_q.size() >= 2) begin
        chk($sformatf("tbl%0d_fetch", i), 32'(obs_q[0]), 32'd0);
        chk($sformatf("tbl%0d_fetch_wait", i), 32'(obs_q[1]), 32'(fwv));
        chk($sformatf("tbl%0d_last", i), 32'(obs_q[obs_q.size()-1]), 32'(tbl[i].last));
      end
      if (i == 6) begin
        we_cnt = 0;
        foreach (obs_q[k]) if (obs_q[k].we_a) we_cnt++;
        chk("stor_we_once", 32'(we_cnt), 32'd1);
      end
      after_checks($sformatf("tbl%0d", i));
    end

    // run=0 holds FETCH with no IR load
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_state", i), 32'(state), 32'(FETCH_ENC));
      chk($sformatf("hold%0d_irwrite", i), 32'(irwrite), 32'd0);
    end

    // reset during LD_ADDR
    opcode = 4'h4; opext = 4'h0; run = 1'b1;
    repeat (3) @(posedge clk);
    #1; run = 1'b0;
    chk("ld_addr_sel", 32'(mem_addr_sel), 32'd1);
    chk("ld_addr_we", 32'(we_a), 32'd0);
    reset = 1'b0; #1;
    chk("ld_rst_state", 32'(state), 32'(FETCH_ENC));
    chk("ld_rst_outputs", 32'(sample()), 32'd0);
    chk("ld_rst_retired", 32'(retired), 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    model_ret = '0;

    // reset during ST drops we_a at once and nothing follows
    opcode = 4'h4; opext = 4'h4; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("st_we", 32'(we_a), 32'd1);
    reset = 1'b0; #1;
    chk("st_rst_we", 32'(we_a), 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("st_post_rst_we", 32'(we_a), 32'd0);
    chk("st_post_rst_state", 32'(state), 32'(FETCH_ENC));

    // random instructions against the model
    for (int t = 0; t < 150; t++) begin
      op  = 4'($urandom_range(0, 15));
      ext = ($urandom_range(0, 1) == 0) ? ext_pool[$urandom_range(0, 10)] : 4'($urandom_range(0, 15));
      cnd = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      fl  = 4'($urandom_range(0, 15));
      build_expected(op, ext, cnd, fl);
      run_instr(op, ext, cnd, fl);
      chk($sformatf("rnd%0d_len op=%0h ext=%0h", t, op, ext), 32'(obs_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
        chk($sformatf("rnd%0d_cyc%0d op=%0h ext=%0h cnd=%0h fl=%0h", t, k, op, ext, cnd, fl),
            32'(obs_q[k]), 32'(exp_q[k]));
      after_checks($sformatf("rnd%0d", t));
    end

    // drive the retire counter to its top value, then one more retire wraps it
    for (int t = 0; t < 300 && model_ret != {TW{1'b1}}; t++) run_instr(4'h7, 4'h0, 4'h0, 4'h0);
    chk("retired_top", 32'(retired), 32'(TW'({TW{1'b1}})));
    run_instr(4'h8, 4'h0, 4'h0, 4'h0);
    chk("retired_wrap", 32'(retired), 32'd0);
    chk("retired_wrap_model", 32'(retired), 32'(model_ret));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
